// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: MTHI/MTLO write at once; MULT/DIV run a fixed
// number of busy cycles, then commit to HI/LO and pulse done.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
   localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

   logic [0:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  opr_q, opr_d;   // bit1: divide, bit0: unsigned
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;

   logic signed [63:0] sa64, sb64, sd64;
   logic [63:0] prod_s, prod_u;
   logic [31:0] dvs, qs, rs, qu, ru;

   // Divisor forced nonzero so the datapath never divides by zero; the
   // commit is suppressed for a zero divisor anyway.
   assign dvs  = (b_q == 32'd0) ? 32'd1 : b_q;
   assign sa64 = {{32{a_q[31]}}, a_q};
   assign sb64 = {{32{b_q[31]}}, b_q};
   assign sd64 = {{32{dvs[31]}}, dvs};

   assign prod_s = sa64 * sb64;
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};
   // 64-bit signed divide keeps 0x80000000 / -1 well defined (lo=0x80000000).
   assign qs = 32'(sa64 / sd64);
   assign rs = 32'(sa64 % sd64);
   assign qu = a_q / dvs;
   assign ru = a_q % dvs;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opr_d   = opr_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     state_d = S_RUN;
                     cnt_d   = op[1] ? DIV_LOAD : MULT_LOAD;
                     opr_d   = op[1:0];
                     a_d     = src_a;
                     b_d     = src_b;
                  end
                  3'd4:    hi_d = src_a;
                  3'd5:    lo_d = src_a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cnt_q == 5'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (!opr_q[1]) begin
                  {hi_d, lo_d} = opr_q[0] ? prod_u : prod_s;
               end else if (b_q != 32'd0) begin
                  hi_d = opr_q[0] ? ru : rs;
                  lo_d = opr_q[0] ? qu : qs;
               end
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         opr_q   <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opr_q   <= opr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of multiply/divide results
// plus hand sequences for MTHI/MTLO, divide-by-zero, back-to-back and reset.
module tb_mult_div_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad = 0;
   logic [31:0] mdl_hi = 32'd0;
   logic [31:0] mdl_lo = 32'd0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   vec_t vecs[11];

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one multiply/divide and check busy length, hold, commit and done.
   // With noise set, an MTHI request is held on start during the whole run.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit noise);
      int n = (o < 3'd2) ? MC : DC;
      bit hold_ok = 1'b1;
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      if (noise) begin
         op = 3'd4; src_a = 32'h0000DEAD; src_b = ~b;
      end else begin
         start = 1'b0; op = 3'd6; src_a = ~a; src_b = ~b;
      end
      chk("accept_flags", {62'd0, busy, done}, 64'b10);
      for (int i = 1; i < n; i++) begin
         @(posedge clk); #1;
         if (!(busy === 1'b1 && done === 1'b0 && hi === mdl_hi && lo === mdl_lo)) hold_ok = 1'b0;
      end
      chk("run_hold", {63'd0, hold_ok}, 64'd1);
      @(posedge clk); #1;
      chk("commit_flags", {62'd0, busy, done}, 64'b01);
      chk("commit_hilo", {hi, lo}, {eh, el});
      start = 1'b0;
      mdl_hi = eh; mdl_lo = el;
      @(posedge clk); #1;
      chk("done_end", {62'd0, busy, done}, 64'b00);
      chk("after_hilo", {hi, lo}, {mdl_hi, mdl_lo});
   endtask

   // Single-cycle ops (MTHI/MTLO/reserved): effect visible right after the edge.
   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = 32'h5555AAAA;
      @(posedge clk); #1;
      start = 1'b0;
      if (o == 3'd4) mdl_hi = a;
      if (o == 3'd5) mdl_lo = a;
      chk("mt_flags", {62'd0, busy, done}, 64'b00);
      chk("mt_hilo", {hi, lo}, {mdl_hi, mdl_lo});
      @(posedge clk); #1;
      chk("mt_no_done", {62'd0, busy, done}, 64'b00);
   endtask

   initial begin
      bit hold_ok;
      bit quiet_ok;

      vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[8]  = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      vecs[9]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vecs[10] = '{3'd0, 32'hFFFF8000, 32'h00010000, 32'hFFFFFFFF, 32'h80000000};

      // Async reset: outputs clear before any clock edge
      #2 reset = 1'b1;
      #1;
      chk("reset_flags", {62'd0, busy, done}, 64'b00);
      chk("reset_hilo", {hi, lo}, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // First vector lands on the first edge after release
      for (int i = 0; i < 11; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, (i % 3) == 0);

      // MTHI/MTLO, then divides by zero leave HI/LO alone
      mt(3'd4, 32'h00000011);
      mt(3'd5, 32'h00000022);
      run_op(3'd2, 32'h00001234, 32'd0, 32'h00000011, 32'h00000022, 1'b0);
      run_op(3'd3, 32'h00000005, 32'd0, 32'h00000011, 32'h00000022, 1'b1);
      mt(3'd6, 32'h00000BAD);
      mt(3'd7, 32'h00000BAD);

      // start held with MULT across completion: re-accept at k+6
      @(negedge clk);
      start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
      @(posedge clk); #1;
      chk("b2b_accept", {62'd0, busy, done}, 64'b10);
      hold_ok = 1'b1;
      for (int i = 1; i < MC; i++) begin
         @(posedge clk); #1;
         if (!(busy === 1'b1 && done === 1'b0)) hold_ok = 1'b0;
      end
      chk("b2b_hold", {63'd0, hold_ok}, 64'd1);
      @(posedge clk); #1;
      chk("b2b_commit_flags", {62'd0, busy, done}, 64'b01);
      chk("b2b_commit_hilo", {hi, lo}, {32'd0, 32'd15});
      @(posedge clk); #1;
      chk("b2b_reaccept", {62'd0, busy, done}, 64'b10);
      start = 1'b0;
      repeat (MC - 1) @(posedge clk);
      @(posedge clk); #1;
      chk("b2b_second_done", {62'd0, busy, done}, 64'b01);
      mdl_hi = 32'd0; mdl_lo = 32'd15;

      // Reset mid-divide: immediate clear, no late done
      mt(3'd4, 32'h000000AA);
      @(negedge clk);
      start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_run_flags", {62'd0, busy, done}, 64'b00);
      chk("rst_run_hilo", {hi, lo}, 64'd0);
      mdl_hi = 32'd0; mdl_lo = 32'd0;
      @(negedge clk) reset = 1'b0;
      quiet_ok = 1'b1;
      for (int i = 0; i < DC + 4; i++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet_ok = 1'b0;
      end
      chk("rst_run_quiet", {63'd0, quiet_ok}, 64'd1);
      run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
